// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC/MAR/MDR/IR strobe sequencer with a bounded memory wait and branch reload
module fetch_sequencer #(
  parameter int WAIT_LIMIT = 15
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        run,
  input  logic        mem_ready,
  input  logic        instr_done,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        halt_req,
  output logic        PCout,
  output logic        MARin,
  output logic        IncPC,
  output logic        PCin,
  output logic [31:0] pc_d,
  output logic        Read,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        exec,
  output logic        halted,
  output logic        fault,
  output logic [15:0] fetch_count
);
  typedef enum logic [2:0] {IDLE, T0, T1, T2, EXEC, BRANCH, HALTED, FAULT} state_t;
  state_t state, nxt;
  logic [7:0] wait_cnt;
  logic [15:0] fcount;
  logic timeout;
  assign timeout = wait_cnt == 8'(WAIT_LIMIT - 1);
  always_ff @(posedge clock or posedge clear)
    if (clear) begin
      state <= IDLE;
      wait_cnt <= '0;
      fcount <= '0;
      pc_d <= '0;
    end else begin
      state <= nxt;
      wait_cnt <= (state == T1 && !mem_ready) ? wait_cnt + 8'd1 : 8'd0;
      if (state == T2) fcount <= fcount + 16'd1;
      if (state == EXEC && instr_done && !halt_req && branch_taken) pc_d <= branch_target;
    end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = halt_req ? HALTED : run ? T0 : IDLE;
      T0:      nxt = T1;
      T1:      nxt = mem_ready ? T2 : timeout ? FAULT : T1;
      T2:      nxt = EXEC;
      EXEC:    nxt = !instr_done ? EXEC : halt_req ? HALTED : branch_taken ? BRANCH : T0;
      BRANCH:  nxt = T0;
      default: nxt = state;
    endcase
  end
  assign PCout       = state == T0;
  assign MARin       = state == T0;
  assign IncPC       = state == T0;
  assign PCin        = state == BRANCH;
  assign Read        = state == T1;
  assign MDRin       = state == T1 && mem_ready;
  assign MDRout      = state == T2;
  assign IRin        = state == T2;
  assign exec        = state == EXEC;
  assign halted      = state == HALTED;
  assign fault       = state == FAULT;
  assign fetch_count = fcount;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed + randomized instruction-level checking of fetch_sequencer
module tb_fetch_sequencer;
  logic clock = 0, clear = 1, run = 0, mem_ready = 0, instr_done = 0, branch_taken = 0, halt_req = 0;
  logic [31:0] branch_target = '0;
  logic PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, exec, halted, fault;
  logic [31:0] pc_d;
  logic [15:0] fetch_count;
  int checks = 0, errors = 0;
  logic [15:0] exp_count = '0;
  logic [31:0] exp_pc = '0;
  localparam logic [10:0] S_NONE = 11'b00000000000, S_T0 = 11'b11100000000,
    S_BR = 11'b00010000000, S_RD = 11'b00001000000, S_MDR = 11'b00000100000,
    S_T2 = 11'b00000011000, S_EX = 11'b00000000100, S_HLT = 11'b00000000010,
    S_FLT = 11'b00000000001;
  logic [10:0] strobes;
  assign strobes = {PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, exec, halted, fault};

  fetch_sequencer #(.WAIT_LIMIT(15)) dut (
    .clock(clock), .clear(clear), .run(run), .mem_ready(mem_ready), .instr_done(instr_done),
    .branch_taken(branch_taken), .branch_target(branch_target), .halt_req(halt_req),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .PCin(PCin), .pc_d(pc_d), .Read(Read),
    .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .exec(exec), .halted(halted), .fault(fault),
    .fetch_count(fetch_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Entered at a negedge while in T0; leaves at a negedge in T0 (or HALTED when hlt).
  task automatic fetch_instr(input int waits, input int exec_dly, input bit br,
                             input logic [31:0] tgt, input bit hlt);
    chk("t0_strobes", 32'(strobes), 32'(S_T0));
    step();
    for (int i = 0; i < waits; i++) begin
      mem_ready = 0;
      #1 chk("t1_wait", 32'(strobes), 32'(S_RD));
      step();
    end
    mem_ready = 1;
    #1 chk("t1_ready", 32'(strobes), 32'(S_RD | S_MDR));
    step();
    mem_ready = 0;
    chk("t2_strobes", 32'(strobes), 32'(S_T2));
    exp_count = exp_count + 16'd1;
    step();
    chk("fetch_count", 32'(fetch_count), 32'(exp_count));
    for (int i = 0; i < exec_dly; i++) begin
      chk("exec_wait", 32'(strobes), 32'(S_EX));
      step();
    end
    instr_done = 1; branch_taken = br; branch_target = tgt; halt_req = hlt;
    #1 chk("exec_done", 32'(strobes), 32'(S_EX));
    step();
    instr_done = 0; branch_taken = 0; halt_req = 0; branch_target = $urandom;
    if (hlt) begin
      chk("halt_strobes", 32'(strobes), 32'(S_HLT));
      chk("halt_pc_kept", pc_d, exp_pc);
    end else if (br) begin
      exp_pc = tgt;
      chk("branch_strobes", 32'(strobes), 32'(S_BR));
      chk("branch_pc_d", pc_d, exp_pc);
      step();
    end
  endtask

  task automatic do_clear();
    clear = 1;
    #1 chk("clear_strobes", 32'(strobes), 32'(S_NONE));
    chk("clear_pc_d", pc_d, 32'd0);
    chk("clear_count", 32'(fetch_count), 32'd0);
    exp_pc = '0; exp_count = '0;
    run = 0; mem_ready = 0; instr_done = 0; branch_taken = 0; halt_req = 0;
    @(negedge clock);
    clear = 0;
  endtask

  initial begin
    repeat (2) @(negedge clock);
    chk("reset_strobes", 32'(strobes), 32'(S_NONE));
    chk("reset_count", 32'(fetch_count), 32'd0);
    clear = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_hold", 32'(strobes), 32'(S_NONE));
    end
    run = 1;
    step();
    run = 0;
    for (int i = 0; i < 4; i++) fetch_instr(0, 0, 0, 32'h0, 0);
    chk("count_after_4", 32'(fetch_count), 32'd4);
    for (int i = 0; i < 10; i++)
      fetch_instr($urandom_range(0, 4), $urandom_range(0, 2), 1'($urandom_range(0, 1)), $urandom, 0);
    fetch_instr(0, 0, 1, 32'h0000_0040, 0);
    chk("pc_d_0x40", pc_d, 32'h0000_0040);
    fetch_instr(3, 1, 0, 32'h0, 0);
    step();
    #1 chk("mid_t1", 32'(strobes), 32'(S_RD));
    do_clear();
    run = 1;
    step();
    run = 0;
    fetch_instr(1, 0, 1, 32'h0000_1234, 1);
    run = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("halt_stays", 32'(strobes), 32'(S_HLT));
    end
    do_clear();
    halt_req = 1; run = 1;
    step();
    chk("idle_halt_priority", 32'(strobes), 32'(S_HLT));
    do_clear();
    run = 1;
    step();
    run = 0;
    chk("to_t0", 32'(strobes), 32'(S_T0));
    step();
    for (int i = 0; i < 15; i++) begin
      chk("timeout_read", 32'(strobes), 32'(S_RD));
      step();
    end
    chk("fault_entered", 32'(strobes), 32'(S_FLT));
    step();
    chk("fault_stays", 32'(strobes), 32'(S_FLT));
    do_clear();
    force dut.fcount = 16'hFFFF;
    #1 release dut.fcount;
    exp_count = 16'hFFFF;
    chk("preload", 32'(fetch_count), 32'h0000_FFFF);
    run = 1;
    step();
    run = 0;
    fetch_instr(0, 0, 0, 32'h0, 0);
    chk("count_wrap", 32'(fetch_count), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Control sequencer that drives the 32-bit program counter and the instruction-fetch path of the CPU datapath. It steps each instruction through the fetch states and waits for memory with a bounded timeout. It hands off to the execute phase and, on a taken branch, loads the PC from a branch target. Its strobes connect directly to the PC register (`PCin`/`IncPC`), the MAR, the MDR and the IR.

## Interface
- `WAIT_LIMIT`, default 15: maximum cycles spent in T1 without `mem_ready` before entering FAULT; legal range 1–255.
- `clock` input 1: single system clock, rising-edge.
- `clear` input 1: asynchronous, active-high reset; forces IDLE and all outputs to reset values.
- `run` input 1: level; starts fetching from IDLE.
- `mem_ready` input 1: memory read data valid; sampled in T1.
- `instr_done` input 1: execute phase complete; one-cycle pulse, sampled in EXEC.
- `branch_taken` input 1: qualifies `instr_done`; PC must be reloaded.
- `branch_target` input 32: new PC value; captured when `instr_done` is high.
- `halt_req` input 1: stop request; sampled in IDLE and on `instr_done`.
- `PCout`, `MARin` output 1: PC driven onto the bus and latched into the MAR.
- `IncPC` output 1: PC increment strobe.
- `PCin` output 1: PC load enable.
- `pc_d` output 32: PC load value.
- `Read`, `MDRin` output 1: memory read request and MDR latch.
- `MDRout`, `IRin` output 1: MDR driven onto the bus and IR latch.
- `exec` output 1: high while in EXEC.
- `halted` output 1: high in HALTED.
- `fault` output 1: high in FAULT.
- `fetch_count` output 16: number of completed fetches.

## Operation
- States: IDLE, T0, T1, T2, EXEC, BRANCH, HALTED, FAULT. The state register is binary encoded and changes on `clock`.
- IDLE:
  - `halt_req`=1 → HALTED. This has priority over `run`.
  - Otherwise `run`=1 → T0; else stay in IDLE.
- T0: asserts `PCout`, `MARin`, `IncPC` for exactly one cycle → T1.
- T1: asserts `Read` every cycle.
  - `mem_ready`=1 → assert `MDRin` in the same cycle → T2.
  - Otherwise increment the 8-bit wait counter.
  - Counter reaching `WAIT_LIMIT` with `mem_ready` still 0 → FAULT.
  - The counter is zeroed on every entry to T1.
- T2: asserts `MDRout`, `IRin` for one cycle; `fetch_count` += 1 (wraps 0xFFFF→0x0000) → EXEC.
- EXEC: asserts `exec`; waits for `instr_done`. When `instr_done`=1:
  - `halt_req`=1 → HALTED. Any branch is discarded; halt wins.
  - Else `branch_taken`=1 → capture `branch_target` into `pc_d` → BRANCH.
  - Else → T0.
- BRANCH: asserts `PCin` for one cycle with `pc_d` stable → T0.
- HALTED, FAULT: terminal states; only `clear` exits them. All strobes are 0.
- `run` is ignored outside IDLE; deasserting it mid-instruction does not stop the sequence.
- Outputs are Moore, decoded from state, except `MDRin`, which is T1 AND `mem_ready`.
- `PCin` and `IncPC` are never high in the same cycle.
- `pc_d` holds its last captured value until the next capture.

## Timing
- Reset (`clear`=1, any time, asynchronous):
  - state IDLE.
  - All strobes 0.
  - `pc_d`=0, `fetch_count`=0, wait counter 0.
  - `exec`/`halted`/`fault`=0.
- Reset mid-fetch aborts immediately; no further strobes are issued.
- Minimum fetch, with `mem_ready` already high: T0, T1, T2 in 3 consecutive cycles. `IRin` is asserted in the 3rd cycle after leaving IDLE.
- Each cycle of T1 without `mem_ready` adds one cycle of latency.
- Taken branch costs one extra cycle (BRANCH) before the next T0.
- `IncPC` in T0 precedes any `PCin` of the same instruction. The branch target therefore overrides the incremented PC.

## Test plan
- Reset and idle:
  - Assert `clear` mid-T1 → outputs all 0 and state IDLE within the same cycle, no clock edge needed.
  - Release `clear`, `run`=0 → stays IDLE for 10 cycles.
- Back-to-back fetches:
  - `run`=1, `mem_ready`=1, `instr_done` pulsed 1 cycle after each EXEC entry.
  - Required per instruction: `IncPC`, `MDRin`, `IRin` pulses in 3 consecutive cycles.
  - `fetch_count`=4 after 4 instructions.
- Wait states:
  - `mem_ready` held low 3 cycles in T1 → `Read` high 4 cycles.
  - `MDRin` asserted only in the 4th cycle; `IRin` in the following cycle.
- Branch:
  - `instr_done`=1, `branch_taken`=1, `branch_target`=0x00000040.
  - Next cycle: `PCin`=1, `pc_d`=0x00000040, `IncPC`=0; the following cycle is T0.
- Halt vs branch:
  - `instr_done`, `branch_taken`, `halt_req` all 1 together → `halted`=1, no `PCin` pulse, and it remains halted until `clear`.
- Timeout and wrap:
  - `WAIT_LIMIT`=15, `mem_ready` stuck low → `fault`=1 after 15 T1 cycles; `Read` then 0.
  - Separately, preload `fetch_count` by 65536 fetches → it reads 0x0000.
